// File: rtl/cpu_pkg.sv
// Shared CPU definitions: pipeline scheduler state encoding and writeback select codes.
package cpu_pkg;

  localparam logic [1:0] WBSEL_ALU = 2'd0;
  localparam logic [1:0] WBSEL_MEM = 2'd1;
  localparam logic [1:0] WBSEL_PC4 = 2'd2;

  typedef enum logic [1:0] {
    SCHED_RUN     = 2'd0,
    SCHED_LDSTALL = 2'd1,
    SCHED_MEMWAIT = 2'd2
  } sched_state_e;

  function automatic logic is_load(input logic [1:0] wbsel);
    return (wbsel == WBSEL_MEM);
  endfunction

  // x0 is never a real producer, so a load targeting it cannot create a hazard.
  function automatic logic load_use(input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic use1, input logic use2,
                                    input logic [4:0] rd, input logic regwr,
                                    input logic isload);
    return isload & regwr & (rd != 5'd0) &
           ((use1 & (rs1 == rd)) | (use2 & (rs2 == rd)));
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // count up on inc, stick at the maximum value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= {W{1'b0}};
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/pipe_sched.sv
// Five-stage pipeline sequencer: resolves load-use, redirect and data-memory-wait stalls
// into per-stage enable/flush strobes; keeps stall/flush counters and a sticky timeout flag.
module pipe_sched
  import cpu_pkg::*;
#(
  parameter int MEM_TMO = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwr,
  input  logic             ex_isload,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             dmem_ack,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             mem_wb_bubble,
  output logic             redirect_take,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [7:0] TMO_C = 8'(MEM_TMO);

  sched_state_e state_r;
  logic         redir_pend_r;
  logic [7:0]   wait_cnt_r;
  logic [7:0]   wait_nxt_s;
  logic         lu_s;
  logic         mw_s;

  assign lu_s = load_use(id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_regwr, ex_isload);
  assign mw_s = mem_req & ~dmem_ack;
  assign wait_nxt_s = (wait_cnt_r == 8'hFF) ? wait_cnt_r : (wait_cnt_r + 8'd1);

  // stage strobes from current state and hazard inputs
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    mem_wb_bubble = 1'b0;
    redirect_take = 1'b0;
    case (state_r)
      SCHED_RUN, SCHED_LDSTALL: begin
        if (mw_s) begin
          pc_en         = 1'b0;
          if_id_en      = 1'b0;
          id_ex_en      = 1'b0;
          ex_mem_en     = 1'b0;
          mem_wb_bubble = 1'b1;
        end else if (ex_redirect) begin
          redirect_take = 1'b1;
          if_id_flush   = 1'b1;
          id_ex_flush   = 1'b1;
        end else if (lu_s && (state_r == SCHED_RUN)) begin
          // the load has already left EX in LDSTALL, so no recheck there
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end else begin
          pc_en = 1'b1;
        end
      end
      SCHED_MEMWAIT: begin
        if (mw_s) begin
          pc_en         = 1'b0;
          if_id_en      = 1'b0;
          id_ex_en      = 1'b0;
          ex_mem_en     = 1'b0;
          mem_wb_bubble = 1'b1;
        end else if (redir_pend_r || ex_redirect) begin
          redirect_take = 1'b1;
          if_id_flush   = 1'b1;
          id_ex_flush   = 1'b1;
        end else begin
          pc_en = 1'b1;
        end
      end
      default: begin
        pc_en = 1'b1;
      end
    endcase
  end

  // scheduler state, pending redirect, wait counter and sticky timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= SCHED_RUN;
      redir_pend_r <= 1'b0;
      wait_cnt_r   <= 8'd0;
      mem_err      <= 1'b0;
    end else begin
      case (state_r)
        SCHED_RUN, SCHED_LDSTALL: begin
          if (mw_s) begin
            state_r      <= SCHED_MEMWAIT;
            wait_cnt_r   <= 8'd1;
            redir_pend_r <= ex_redirect;
          end else if (ex_redirect) begin
            state_r <= SCHED_RUN;
          end else if (lu_s && (state_r == SCHED_RUN)) begin
            state_r <= SCHED_LDSTALL;
          end else begin
            state_r <= SCHED_RUN;
          end
        end
        SCHED_MEMWAIT: begin
          if (mw_s) begin
            wait_cnt_r   <= wait_nxt_s;
            redir_pend_r <= redir_pend_r | ex_redirect;
            if (wait_nxt_s >= TMO_C) begin
              mem_err <= 1'b1;
            end else begin
              mem_err <= mem_err;
            end
          end else begin
            state_r      <= SCHED_RUN;
            redir_pend_r <= 1'b0;
            wait_cnt_r   <= 8'd0;
          end
        end
        default: begin
          state_r      <= SCHED_RUN;
          redir_pend_r <= 1'b0;
          wait_cnt_r   <= 8'd0;
        end
      endcase
    end
  end

  sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~pc_en),
    .cnt   (stall_cnt)
  );

  sat_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (redirect_take),
    .cnt   (flush_cnt)
  );

endmodule

// File: doc/pipe_sched.md
Name: pipe_sched

Overview:
- Sequences the five-stage RV32 pipeline (IF, ID, EX, MEM, WB) by driving per-stage enable and flush strobes for the PC register and the four pipeline registers (if_id, id_ex, ex_mem, mem_wb).
- Resolves three stall sources: load-use hazards, EX-stage branch/jump redirects and multi-cycle data-memory waits.
- Sits beside the hazard forwarding unit and the PC controller in the top level.
- Keeps saturating performance counters and a sticky memory-timeout error.

Parameters:
MEM_TMO, 16, cycles a data access may wait for dmem_ack before mem_err sets (range 2..255)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
id_rs1  in  5  rs1 address of the instruction in ID
id_rs2  in  5  rs2 address of the instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  destination of the instruction in EX
ex_regwr  in  1  EX instruction writes the register file
ex_isload  in  1  EX instruction is a load (wbsel = memory)
ex_redirect  in  1  EX resolved a taken branch or a jump
mem_req  in  1  MEM stage holds a load/store
dmem_ack  in  1  data memory completes the access this cycle
pc_en  out  1  PC register loads
if_id_en  out  1  if_id register loads
if_id_flush  out  1  if_id loads a NOP (overrides en)
id_ex_en  out  1  id_ex register loads
id_ex_flush  out  1  id_ex loads a bubble (overrides en)
ex_mem_en  out  1  ex_mem register loads
mem_wb_en  out  1  mem_wb register loads
mem_wb_bubble  out  1  mem_wb loads a bubble (regwr = 0)
redirect_take  out  1  PC mux must select the EX target this cycle
mem_err  out  1  sticky timeout flag
stall_cnt  out  CNT_W  cycles with pc_en = 0
flush_cnt  out  CNT_W  redirects applied

Behaviour:
- Reset (async, rst_n = 0):
  - State goes to RUN; mem_err = 0; counters = 0; redir_pend = 0; wait counter = 0.
  - Outputs: all enables = 1; flushes, bubble and redirect_take = 0.
- All enable, flush and bubble outputs are combinational from state and inputs. State, counters and flags are registered.
- States:
  - RUN: normal operation.
  - LDSTALL: one-cycle bubble.
  - MEMWAIT: memory wait.
- Load-use condition (lu): ex_isload & ex_regwr & ex_rd != 0 & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
- Memory wait condition (mw): mem_req & !dmem_ack.
- Priority within one cycle: mw, then redirect, then lu.
- RUN:
  - If mw: pc_en = if_id_en = id_ex_en = ex_mem_en = 0; mem_wb_en = 1 with mem_wb_bubble = 1.
    - If ex_redirect is also high, set redir_pend.
    - Next state MEMWAIT; wait counter = 1.
  - Else if ex_redirect: redirect_take = 1, pc_en = 1, if_id_flush = 1, id_ex_flush = 1. This squashes 2 wrong-path instructions; flush_cnt increments.
  - Else if lu: pc_en = 0, if_id_en = 0, id_ex_flush = 1. Next state LDSTALL.
  - Else: all enables = 1.
- LDSTALL:
  - All enables = 1, with no hazard recheck of the original load (it has left EX).
  - A new redirect or mw is handled exactly as in RUN.
  - Next state is RUN, or MEMWAIT on mw.
- MEMWAIT:
  - Outputs are identical to the RUN mw case while mw holds; the wait counter increments.
  - When the wait counter reaches MEM_TMO, mem_err sets (sticky until reset) and the pipeline stays frozen.
  - On dmem_ack: all enables = 1 and mem_wb takes real data. Next state RUN.
    - If redir_pend is set, redirect_take, if_id_flush and id_ex_flush are asserted in this same cycle; then redir_pend clears and flush_cnt increments.
- ex_redirect seen during MEMWAIT (EX is frozen, so it is held stable) sets redir_pend once; it is not counted twice.
- stall_cnt increments on every cycle with pc_en = 0. Both counters saturate at all-ones.
- Reset mid-stall returns to RUN immediately and drops any pending redirect.
- lu with ex_rd = 0 never stalls.

Decomposition:
- Shared package cpu_pkg gains:
  - state enum SCHED_RUN / SCHED_LDSTALL / SCHED_MEMWAIT (2-bit);
  - the WBSEL_MEM constant used to derive ex_isload.
- One natural sub-module: sat_cnt (parameterised width, increment enable, saturating), instantiated twice.

Test Plan:
- Load x5 in EX, ID `add x6,x5,x1` (id_use_rs1 = 1) -> one cycle pc_en = 0, if_id_en = 0, id_ex_flush = 1; next cycle all enables = 1; stall_cnt = 1.
- Load with ex_rd = 0 and id_rs1 = 0 -> no stall; stall_cnt stays 0.
- ex_redirect = 1 in RUN -> same cycle: redirect_take = 1, if_id_flush = 1, id_ex_flush = 1, pc_en = 1; flush_cnt = 1.
- mem_req = 1 with dmem_ack low for 3 cycles, ex_redirect = 1 throughout -> 3 cycles frozen with mem_wb_bubble = 1. Ack cycle: redirect_take = 1 plus both flushes. flush_cnt = 1, stall_cnt = 3.
- MEM_TMO = 4, dmem_ack never asserted -> mem_err rises when the wait counter reaches 4 and stays high after a later ack; cleared only by rst_n = 0.
- rst_n pulsed low during MEMWAIT with redir_pend set -> outputs return asynchronously to reset values; after release no redirect_take is issued.
